// File: rtl/pc_redirect_unit.sv
// Purpose : fetch-PC owner; resolves branch/JAL/JALR redirects from EX, issues flushes,
//           and drives a valid/ready fetch request to instruction memory.
// Latency : redirect target reaches PC one edge after the redirect (or after acceptance in PEND).
// Backpressure: PC is held while if_req=1 and if_ready=0; a redirect that cannot be accepted
//           is parked in pend_target and applied at the next accepted fetch.
//
// Ports:
//   clk, rstn      - clock (rising edge), asynchronous active-low reset
//   EX_valid       - EX stage holds a real instruction
//   Op_EX          - EX opcode (branch / JAL / JALR decoded here)
//   Zero           - branch-taken flag from the EX comparator
//   PC_EX, Imm_EX  - PC and sign-extended immediate of the EX instruction
//   RD1_EX         - rs1 value, JALR base
//   stall          - hazard stall, holds the sequential fetch PC
//   if_ready       - instruction memory accepts the request this cycle
//   if_req, PC     - fetch request valid / fetch address
//   if_drop        - returned instruction for this cycle's accepted fetch must be discarded
//   flush          - kill IF/ID and ID/EX at the next edge
//   misalign       - one-cycle pulse after a redirect whose raw target was misaligned
//   redirect_cnt   - saturating count of redirect cycles
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        EX_valid,
    input  logic [6:0]  Op_EX,
    input  logic        Zero,
    input  logic [31:0] PC_EX,
    input  logic [31:0] Imm_EX,
    input  logic [31:0] RD1_EX,
    input  logic        stall,
    input  logic        if_ready,
    output logic        if_req,
    output logic [31:0] PC,
    output logic        if_drop,
    output logic        flush,
    output logic        misalign,
    output logic [15:0] redirect_cnt
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pend_target;

    // ------------------------------------------------------------------
    // Redirect decode and target computation
    // ------------------------------------------------------------------
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        redirect;
    logic [31:0] tgt_base;
    logic [31:0] tgt_sum;
    logic [31:0] raw_target;
    logic        tgt_misaligned;
    logic [31:0] target;
    logic        accepted;

    always_comb begin
        is_branch = (Op_EX == OP_BRANCH);
        is_jal    = (Op_EX == OP_JAL);
        is_jalr   = (Op_EX == OP_JALR);
        redirect  = EX_valid & ((is_branch & Zero) | is_jal | is_jalr);

        // JALR adds to rs1, branch/JAL add to the instruction's own PC.
        tgt_base  = is_jalr ? RD1_EX : PC_EX;
        tgt_sum   = tgt_base + Imm_EX;
        // JALR clears bit 0 before the alignment check, so only bit 1 can trap it.
        raw_target = is_jalr ? (tgt_sum & ~32'h1) : tgt_sum;

        tgt_misaligned = (raw_target[1:0] != 2'b00);
        target         = tgt_misaligned ? TRAP_PC : raw_target;
    end

    assign accepted = if_req & if_ready;
    assign flush    = redirect;
    // The word fetched at the held PC while a redirect was pending is stale.
    assign if_drop  = (state == PEND) & accepted;

    // ------------------------------------------------------------------
    // Fetch PC state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= RUN;
            PC          <= RESET_PC;
            pend_target <= 32'h0;
            if_req      <= 1'b0;
        end else begin
            if_req <= 1'b1;
            case (state)
                RUN: begin
                    if (redirect) begin
                        // Redirect overrides stall. PC must not move under an
                        // unaccepted request, so the target is parked instead.
                        if (accepted) begin
                            PC <= target;
                        end else begin
                            pend_target <= target;
                            state       <= PEND;
                        end
                    end else if (accepted && !stall) begin
                        PC <= PC + 32'd4;
                    end
                end
                PEND: begin
                    if (accepted) begin
                        // A redirect arriving in the acceptance cycle is younger
                        // than the parked one and wins.
                        PC    <= redirect ? target : pend_target;
                        state <= RUN;
                    end else if (redirect) begin
                        pend_target <= target;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status: misalign pulse and saturating redirect counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign     <= 1'b0;
            redirect_cnt <= 16'h0;
        end else begin
            misalign <= redirect & tgt_misaligned;
            if (redirect && (redirect_cnt != 16'hFFFF)) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
        end
    end

endmodule
